spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI mode-0 peripheral (slave) end of the team's SPI link: receives MSB-first words from the `spi` master on mosi and returns words on miso.
- All logic runs on the fabric clock `clk`.
- The SPI pins (`sclk`, `cs`, `mosi`) are asynchronous to `clk`; they are synchronised and edge-detected internally.
- Parallel side provides a one-word TX buffer with ready/write handshake and an RX holding register with valid/read handshake and sticky overrun.

Parameters:
- SIZE, 8, word width in bits.
- SYNC_STAGES, 2, synchroniser depth for sclk/cs/mosi (≥2).
- DEFAULT_TX, 8'hFF, word shifted out when the TX buffer is empty at load time.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- sclk  input  1  SPI clock from master; idles low.
- cs  input  1  chip select, active-low.
- mosi  input  1  serial data from master.
- miso  output  1  serial data to master.
- miso_oe  output  1  high while cs is low (synchronised); drives the external tri-state.
- tx_data  input  SIZE  next word to send.
- tx_wr  input  1  write strobe; accepted only when tx_ready=1.
- tx_ready  output  1  TX buffer empty.
- rx_data  output  SIZE  last complete received word.
- rx_valid  output  1  rx_data holds an unread word.
- rx_rd  input  1  consumer read strobe; clears rx_valid.
- overrun  output  1  sticky flag: a word completed while rx_valid=1; cleared only by rst.

Behaviour:
- Reset values:
  - miso=0, miso_oe=0, rx_data=0, rx_valid=0, overrun=0, tx_ready=1.
  - Internal: bit_cnt=0, shift registers 0, state IDLE.
- Synchronisation and edge detection:
  - sclk, cs and mosi each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last synchroniser stage with one additional flop.
  - Pin-to-internal latency is SYNC_STAGES+1 clk.
- Timing requirement on the master: sclk high time and low time each ≥ SYNC_STAGES+2 clk periods. Behaviour is undefined for faster sclk.
- FSM states: IDLE, LOAD, SHIFT.
- IDLE:
  - miso_oe=0.
  - Synchronised cs falling -> LOAD.
- LOAD (one cycle):
  - tx_shift <= buffer if tx_ready=0, else DEFAULT_TX.
  - Buffer marked empty (tx_ready=1 next cycle).
  - miso <= MSB of the loaded word; bit_cnt=0; miso_oe=1.
  - -> SHIFT.
- SHIFT, sclk rising:
  - rx_shift <= {rx_shift[SIZE-2:0], mosi_sync}; bit_cnt++.
  - At bit_cnt==SIZE-1 (word complete): rx_data <= assembled word; rx_valid <= 1; bit_cnt <= 0.
  - If rx_valid was already 1 and rx_rd is not asserted in that cycle: overrun <= 1 and rx_data is overwritten.
- SHIFT, sclk falling:
  - If bit_cnt==0 after a completed word: reload tx_shift as in LOAD (back-to-back words without cs deassert) and present its MSB on miso.
  - Otherwise shift tx_shift left and set miso to the new MSB.
- cs rising (synchronised) in any state:
  - -> IDLE; miso_oe=0; bit_cnt=0.
  - Partial RX word is discarded with no rx_valid.
  - A TX word already loaded is lost, not re-queued.
- TX handshake:
  - tx_wr with tx_ready=1 captures tx_data; tx_ready -> 0 next cycle.
  - tx_wr with tx_ready=0 is ignored; buffer unchanged.
  - tx_wr in the same cycle as a load: the load uses the old buffer state, the write is accepted, and tx_ready ends at 0.
- RX handshake:
  - rx_rd clears rx_valid next cycle.
  - rx_rd coincident with word completion: rx_valid stays 1, new data is kept, no overrun.
- rst asserted mid-transfer: immediate return to reset values. After release, the block waits in IDLE for the next cs falling edge, even if cs is already low.
- miso is 0 whenever miso_oe=0.

Test Plan:
1. Single word: write tx_data=8'h9A, then master sends 8'h53 with cs low and sclk=clk/8 -> master receives 8'h9A on miso; rx_data=8'h53; rx_valid=1 within SYNC_STAGES+2 clk of the 8th sclk rise; overrun=0.
2. Empty TX: no tx_wr, master sends 8'hA5 -> miso returns 8'hFF; rx_data=8'hA5.
3. Back-to-back: cs held low for 16 sclk; TX buffer holds 8'h01, then 8'h02 written after tx_ready rises; master sends 8'h11, 8'h22 -> miso returns 8'h01, 8'h02; rx_valid pulses twice; with rx_rd after each word, overrun=0.
4. Overrun: two words 8'h33, 8'h44, no rx_rd -> rx_data=8'h44, rx_valid=1, overrun=1 and stays 1 until rst.
5. Abort: cs rises after 4 sclk of 8'hF0 -> rx_valid stays 0; miso_oe=0 within SYNC_STAGES+2 clk. Next full word 8'h0F is received correctly as 8'h0F.
6. Reset mid-word: assert rst after 3 bits -> all outputs at reset values immediately. After release with cs still low, no activity until cs toggles high then low; the subsequent word is received correctly.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 peripheral with synchronised pin inputs, a one-word TX buffer
// and an RX holding register with sticky overrun.
module spi_slave #(
    parameter int              SIZE        = 8,
    parameter int              SYNC_STAGES = 2,
    parameter logic [SIZE-1:0] DEFAULT_TX  = 8'hFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sclk,
    input  logic            cs,
    input  logic            mosi,
    output logic            miso,
    output logic            miso_oe,
    input  logic [SIZE-1:0] tx_data,
    input  logic            tx_wr,
    output logic            tx_ready,
    output logic [SIZE-1:0] rx_data,
    output logic            rx_valid,
    input  logic            rx_rd,
    output logic            overrun
);
    localparam int CW = $clog2(SIZE);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t state, state_nx;
    logic [SYNC_STAGES-1:0] sclk_s, cs_s, mosi_s;
    logic sclk_d, cs_d;
    logic [SIZE-1:0] tx_buf, tx_shift, rx_shift;
    logic [CW-1:0] bit_cnt;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall, load, shift_rx, shift_tx, word_done;

    assign sclk_rise = sclk_s[SYNC_STAGES-1] & ~sclk_d;
    assign sclk_fall = ~sclk_s[SYNC_STAGES-1] & sclk_d;
    assign cs_rise   = cs_s[SYNC_STAGES-1] & ~cs_d;
    assign cs_fall   = ~cs_s[SYNC_STAGES-1] & cs_d;
    assign shift_rx  = state == SHIFT && sclk_rise && !cs_rise;
    assign shift_tx  = state == SHIFT && sclk_fall && !cs_rise;
    assign word_done = shift_rx && bit_cnt == LAST;
    // bit_cnt==0 on a falling edge in SHIFT only follows a completed word
    assign load      = !cs_rise && (state == LOAD || (shift_tx && bit_cnt == '0));
    assign miso_oe   = state != IDLE;
    assign miso      = miso_oe & tx_shift[SIZE-1];

    always_comb begin
        state_nx = cs_rise ? IDLE :
                   (state == IDLE && cs_fall) ? LOAD :
                   (state == LOAD) ? SHIFT : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_s   <= '0;
            cs_s     <= '0;
            mosi_s   <= '0;
            sclk_d   <= 1'b0;
            cs_d     <= 1'b0;
            state    <= IDLE;
            tx_buf   <= '0;
            tx_ready <= 1'b1;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
            cs_s   <= {cs_s[SYNC_STAGES-2:0], cs};
            mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi};
            sclk_d <= sclk_s[SYNC_STAGES-1];
            cs_d   <= cs_s[SYNC_STAGES-1];
            state  <= state_nx;
            if (tx_wr && tx_ready) begin
                tx_buf   <= tx_data;
                tx_ready <= 1'b0;
            end else if (load) begin
                tx_ready <= 1'b1;
            end
            if (load)
                tx_shift <= tx_ready ? DEFAULT_TX : tx_buf;
            else if (shift_tx)
                tx_shift <= {tx_shift[SIZE-2:0], 1'b0};
            else if (state_nx == IDLE)
                tx_shift <= '0;
            if (state != SHIFT || cs_rise)
                bit_cnt <= '0;
            else if (shift_rx) begin
                rx_shift <= {rx_shift[SIZE-2:0], mosi_s[SYNC_STAGES-1]};
                bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
            end
            if (word_done) begin
                rx_data  <= {rx_shift[SIZE-2:0], mosi_s[SYNC_STAGES-1]};
                rx_valid <= 1'b1;
                if (rx_valid && !rx_rd)
                    overrun <= 1'b1;
            end else if (rx_rd) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized SPI-master bench with an RX scoreboard and a
// word-level model of the TX buffer and overrun flag.
module tb_spi_slave;
    logic clk = 1'b0;
    logic rst, sclk, cs, mosi, miso, miso_oe, tx_wr, tx_ready, rx_valid, rx_rd, overrun;
    logic [7:0] tx_data, rx_data;

    int n_cmp = 0, n_bad = 0, half = 4;
    bit auto_rd = 1'b1;
    logic [7:0] rx_q[$];
    logic [7:0] buf_m;
    bit buf_full, ovr_m;

    always #5 clk = ~clk;

    spi_slave #(.SIZE(8), .SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
        .miso_oe(miso_oe), .tx_data(tx_data), .tx_wr(tx_wr), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_rd(rx_rd), .overrun(overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // TX buffer model: one slot, writes ignored while full, each word start empties it
    task automatic write_tx(input logic [7:0] w);
        chk("tx_ready", tx_ready, !buf_full);
        tx_data = w;
        tx_wr = 1'b1;
        clks(1);
        tx_wr = 1'b0;
        if (!buf_full) begin
            buf_m = w;
            buf_full = 1'b1;
        end
    endtask

    function automatic logic [7:0] take_tx();
        take_tx = buf_full ? buf_m : 8'hFF;
        buf_full = 1'b0;
    endfunction

    task automatic check_reset_outputs();
        chk("rst_miso", miso, 0);
        chk("rst_miso_oe", miso_oe, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_tx_ready", tx_ready, 1);
    endtask

    task automatic begin_cs();
        cs = 1'b0;
        clks(6);
    endtask

    task automatic end_cs();
        clks(half);
        cs = 1'b1;
        clks(8);
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && rx_q.size() != 0; t++) clks(1);
        chk("rx_drain", rx_q.size(), 0);
    endtask

    task automatic word(input logic [7:0] mo, input int nbits, input bit push,
                        input bit wr_next, input logic [7:0] nxt);
        logic [7:0] exp, mi;
        exp = take_tx();
        mi = 8'h00;
        if (push) rx_q.push_back(mo);
        for (int i = 0; i < nbits; i++) begin
            if (wr_next && i == 3) write_tx(nxt);
            mosi = mo[7-i];
            clks(half);
            sclk = 1'b1;
            mi[7-i] = miso;
            clks(half);
            sclk = 1'b0;
        end
        if (nbits == 8) chk("miso_word", mi, exp);
    endtask

    // monitor: consumes each presented word and compares it against the scoreboard
    initial begin
        rx_rd = 1'b0;
        forever begin
            @(negedge clk);
            rx_rd = 1'b0;
            if (rx_valid && auto_rd) begin
                if (rx_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rx: got %0h, expected no word", rx_data);
                end else begin
                    chk("rx_data", rx_data, rx_q.pop_front());
                end
                rx_rd = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        int nw;
        bit wn;
        rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; tx_wr = 1'b0; tx_data = 8'h00;
        buf_full = 1'b0; ovr_m = 1'b0;
        clks(3);
        check_reset_outputs();
        rst = 1'b0;
        clks(5);

        write_tx(8'h9A);
        begin_cs();
        chk("miso_oe_active", miso_oe, 1);
        word(8'h53, 8, 1, 0, 8'h00);
        end_cs();
        drain();
        chk("overrun", overrun, ovr_m);

        begin_cs();
        word(8'hA5, 8, 1, 0, 8'h00);
        end_cs();
        drain();

        write_tx(8'h01);
        begin_cs();
        word(8'h11, 8, 1, 1, 8'h02);
        word(8'h22, 8, 1, 0, 8'h00);
        end_cs();
        drain();
        chk("overrun", overrun, ovr_m);

        auto_rd = 1'b0;
        begin_cs();
        word(8'h33, 8, 0, 0, 8'h00);
        word(8'h44, 8, 1, 0, 8'h00);
        end_cs();
        chk("ovr_rx_data", rx_data, 8'h44);
        chk("ovr_rx_valid", rx_valid, 1);
        chk("ovr_flag", overrun, 1);
        ovr_m = 1'b1;
        auto_rd = 1'b1;
        drain();

        begin_cs();
        word(8'hF0, 4, 0, 0, 8'h00);
        clks(half);
        cs = 1'b1;
        clks(4);
        chk("abort_miso_oe", miso_oe, 0);
        chk("abort_miso", miso, 0);
        clks(4);
        chk("abort_rx_valid", rx_valid, 0);
        begin_cs();
        word(8'h0F, 8, 1, 0, 8'h00);
        end_cs();
        drain();
        chk("overrun_sticky", overrun, ovr_m);

        begin_cs();
        word(8'hC3, 3, 0, 0, 8'h00);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        buf_full = 1'b0;
        ovr_m = 1'b0;
        clks(2);
        rst = 1'b0;
        clks(2);
        for (int i = 0; i < 8; i++) begin
            mosi = 1'($urandom);
            clks(half);
            sclk = 1'b1;
            clks(half);
            sclk = 1'b0;
        end
        chk("post_rst_rx_valid", rx_valid, 0);
        chk("post_rst_miso_oe", miso_oe, 0);
        cs = 1'b1;
        clks(8);
        begin_cs();
        word(8'h5C, 8, 1, 0, 8'h00);
        end_cs();
        drain();
        chk("overrun", overrun, ovr_m);

        for (int f = 0; f < 25; f++) begin
            nw = $urandom_range(1, 3);
            half = $urandom_range(4, 6);
            if ($urandom_range(0, 1) == 1) write_tx(8'($urandom));
            if ($urandom_range(0, 3) == 0) write_tx(8'($urandom));
            begin_cs();
            for (int w = 0; w < nw; w++) begin
                wn = (w < nw - 1) && ($urandom_range(0, 1) == 1);
                word(8'($urandom), 8, 1, wn, 8'($urandom));
            end
            end_cs();
            drain();
            chk("overrun", overrun, ovr_m);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
